lsu: RTL and testbench

Load/store unit that initiates every data-memory access from the CPU datapath. It accepts one load or store per handshake, drives the word-addressed data memory's address, `dmwr`, and `din`, and captures its registered `dout`. It performs read-modify-write for byte and halfword stores and lane extraction with sign or zero extension for loads. It sits between the EX/MEM stage and DM.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_lane_mux.sv | 67 ++++++
 rtl/lsu.sv | 164 ++++++++++++++++
 tb/tb_lsu.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: access-size encodings and the
// control FSM state type. Imported by lsu and lsu_lane_mux.
// -----------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_RSP
  } state_t;

endpackage

// File: rtl/lsu_lane_mux.sv
// -----------------------------------------------------------------------------
// lsu_lane_mux
// Purely combinational lane logic for the load/store unit.
//   lane    : byte address bits [1:0] of the access (little-endian lanes)
//   size    : access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   sgn     : 1 = sign-extend loads, 0 = zero-extend
//   rd_word : word read back from data memory
//   ld_data : selected lane, extended to 32 bits
//   wdata   : right-aligned store data          (LSU_SUBWORD_EN only)
//   merged  : rd_word with the store lane(s) replaced (LSU_SUBWORD_EN only)
// Build option: `define LSU_SUBWORD_EN adds the store merge path.
// -----------------------------------------------------------------------------
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] rd_word,
`ifdef LSU_SUBWORD_EN
  input  logic [31:0] wdata,
  output logic [31:0] merged,
`endif
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

    case (size)
      SZ_BYTE: ld_data = {{24{sgn & byte_sel[7]}}, byte_sel};
      SZ_HALF: ld_data = {{16{sgn & half_sel[15]}}, half_sel};
      default: ld_data = rd_word;
    endcase
  end

`ifdef LSU_SUBWORD_EN
  always_comb begin
    merged = rd_word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end
`endif

endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu
// Load/store unit between the EX/MEM stage and a word-addressed data memory
// whose read data is registered inside the memory. One request is accepted per
// valid/ready handshake; sub-word stores use read-modify-write.
//
// Parameters: DM_WORDS - number of implemented DM words (higher index = error)
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_we, req_size, req_signed, req_addr, req_wdata   request fields
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata, rsp_err  load data / error flag, zero outside rsp_valid
//   dm_addr, dm_dmwr, dm_din, dm_dout   data-memory port
// Build option: `define LSU_SUBWORD_EN enables byte/halfword accesses;
// without it only word accesses are legal and the merge path is removed.
// -----------------------------------------------------------------------------
module lsu
  import lsu_pkg::*;
#(
  parameter int DM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [9:0]  dm_addr,
  output logic        dm_dmwr,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout
);

  localparam logic [10:0] DM_LIMIT = 11'(DM_WORDS);

  state_t      state;
  logic        accept;
  logic        req_err;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [31:0] ld_data;
`ifdef LSU_SUBWORD_EN
  logic        we_q;
  logic [31:0] wdata_q;
  logic [31:0] merged;
`endif

  assign accept = req_valid && req_ready;

  always_comb begin
    case (req_size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
`ifndef LSU_SUBWORD_EN
    if (req_size != SZ_WORD) req_err = 1'b1;
`endif
    if ({1'b0, req_addr[11:2]} >= DM_LIMIT) req_err = 1'b1;
  end

  // Request fields are only consumed after an accept, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lane_q  <= req_addr[1:0];
      size_q  <= req_size;
      sgn_q   <= req_signed;
`ifdef LSU_SUBWORD_EN
      we_q    <= req_we;
      wdata_q <= req_wdata;
`endif
    end
  end

  lsu_lane_mux u_lane_mux (
    .lane    (lane_q),
    .size    (size_q),
    .sgn     (sgn_q),
    .rd_word (dm_dout),
`ifdef LSU_SUBWORD_EN
    .wdata   (wdata_q),
    .merged  (merged),
`endif
    .ld_data (ld_data)
  );

  // Control FSM; every output is registered and set on the transition into
  // the state that owns it. dm_din doubles as the merge register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      dm_dmwr   <= 1'b0;
      dm_addr   <= '0;
      dm_din    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (req_err) begin
              state     <= ST_RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              dm_addr <= req_addr[11:2];
              if (req_we && req_size == SZ_WORD) begin
                state   <= ST_WR;
                dm_dmwr <= 1'b1;
                dm_din  <= req_wdata;
              end else begin
                state <= ST_RD;
              end
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_RD: state <= ST_CAP;
        ST_CAP: begin
`ifdef LSU_SUBWORD_EN
          if (we_q) begin
            state   <= ST_WR;
            dm_dmwr <= 1'b1;
            dm_din  <= merged;
          end else
`endif
          begin
            state     <= ST_RSP;
            rsp_valid <= 1'b1;
            rsp_rdata <= ld_data;
          end
        end
        ST_WR: begin
          state     <= ST_RSP;
          dm_dmwr   <= 1'b0;
          dm_din    <= '0;
          rsp_valid <= 1'b1;
        end
        ST_RSP: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu
// Self-checking bench for lsu: directed scenarios plus randomized requests
// compared against a behavioural word-array model of the data memory.
// Works with or without `define LSU_SUBWORD_EN.
// -----------------------------------------------------------------------------
module tb_lsu;
  import lsu_pkg::*;

  localparam int DM_WORDS = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [9:0]  dm_addr;
  logic        dm_dmwr;
  logic [31:0] dm_din, dm_dout;

  always #5 clk = ~clk;

  lsu #(.DM_WORDS(DM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dm_addr(dm_addr), .dm_dmwr(dm_dmwr),
    .dm_din(dm_din), .dm_dout(dm_dout)
  );

  // Data memory: registered read while not writing.
  logic [31:0] mem [1024];
  bit          mem_init_done = 1'b0;

  function automatic logic [31:0] init_val(int i);
    if (i == 3) return 32'h8899AABB;
    return 32'h1F2E3D4C ^ (32'(i) * 32'h9E3779B9);
  endfunction

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      mem_init_done <= 1'b1;
    end else if (dm_dmwr) begin
      mem[dm_addr] <= dm_din;
    end else begin
      dm_dout <= mem[dm_addr];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [DM_WORDS];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit model_err(input logic [1:0] size, input logic [11:0] a);
    int widx = int'(a[11:2]);
    if (widx >= DM_WORDS) return 1'b1;
    if (size == 2'b11) return 1'b1;
`ifndef LSU_SUBWORD_EN
    if (size != 2'b10) return 1'b1;
`endif
    if (size == 2'b01 && a[0]) return 1'b1;
    if (size == 2'b10 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_lat(input bit e, input bit we, input logic [1:0] size);
    if (e) return 1;
    if (!we) return 3;
    return (size == 2'b10) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input bit sgn,
                                             input logic [11:0] a);
    logic [31:0] w, v;
    int sh;
    w = ref_mem[int'(a[11:2])];
    if (size == 2'b00) begin
      sh = 8 * int'(a[1:0]);
      v = (w >> sh) & 32'hFF;
      if (sgn && v[7]) v = v | 32'hFFFFFF00;
    end else if (size == 2'b01) begin
      sh = a[1] ? 16 : 0;
      v = (w >> sh) & 32'hFFFF;
      if (sgn && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [11:0] a, input logic [31:0] wd);
    logic [31:0] mask, w;
    int sh, idx;
    idx = int'(a[11:2]);
    w = ref_mem[idx];
    if (size == 2'b00) begin
      sh = 8 * int'(a[1:0]);
      mask = 32'hFF << sh;
    end else if (size == 2'b01) begin
      sh = a[1] ? 16 : 0;
      mask = 32'hFFFF << sh;
    end else begin
      sh = 0;
      mask = 32'hFFFFFFFF;
    end
    ref_mem[idx] = (w & ~mask) | ((wd << sh) & mask);
  endtask

  // Issue one request (called at a negedge) and check the full response.
  task automatic do_req(input bit we, input logic [1:0] size, input bit sgn,
                        input logic [11:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat, output logic e_got);
    bit          e_err;
    int          e_lat, w, dmwr_n, dmwr_cyc, busy_rdy;
    logic [31:0] e_rd;
    e_err = model_err(size, a);
    e_lat = model_lat(e_err, we, size);
    e_rd  = (e_err || we) ? 32'h0 : model_load(size, sgn, a);
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rd = 32'h0; e_got = 1'b0;
    dmwr_n = 0; dmwr_cyc = 0; busy_rdy = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (dm_dmwr) begin dmwr_n++; dmwr_cyc = c; end
      if (req_ready) busy_rdy++;
      if (rsp_valid) begin
        lat = c; rd = rsp_rdata; e_got = rsp_err;
        break;
      end
    end
    check("latency",   32'(lat), 32'(e_lat));
    check("rsp_err",   {31'b0, e_got}, {31'b0, e_err});
    check("rsp_rdata", rd, e_rd);
    check("dmwr_count", 32'(dmwr_n), (!e_err && we) ? 32'd1 : 32'd0);
    check("dmwr_cycle", 32'(dmwr_cyc), (!e_err && we) ? 32'(e_lat - 1) : 32'd0);
    check("busy_ready", 32'(busy_rdy), 32'd0);
    @(negedge clk);
    check("post_ctrl", {28'b0, rsp_valid, rsp_err, req_ready, dm_dmwr}, 32'b0010);
    check("post_data", rsp_rdata | dm_din, 32'h0);
    if (!e_err && we) model_store(size, a, wd);
  endtask

  // Accept a request, reset at the end of cycle rst_cyc, check the abort.
  task automatic reset_mid(input bit we, input logic [1:0] size, input logic [11:0] a,
                           input logic [31:0] wd, input int rst_cyc, input bit write_done);
    int early_rsp;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = 1'b0;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    early_rsp = 0;
    for (int c = 1; c <= rst_cyc; c++) begin
      @(negedge clk);
      if (rsp_valid) early_rsp++;
    end
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_ctrl", {28'b0, rsp_valid, rsp_err, dm_dmwr, req_ready}, 32'h0);
      check("rst_data", rsp_rdata | dm_din, 32'h0);
      check("rst_addr", {22'b0, dm_addr}, 32'h0);
    end
    rst_n = 1'b1;
    check("rdy_at_release", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check("rdy_after_release", {31'b0, req_ready}, 32'd1);
    check("no_rsp_abort", 32'(early_rsp) + {31'b0, rsp_valid} + {31'b0, dm_dmwr}, 32'd0);
    if (write_done) model_store(size, a, wd);
  endtask

  logic [31:0] rd;
  int          lat;
  logic        eg;

  initial begin
    for (int i = 0; i < DM_WORDS; i++) ref_mem[i] = init_val(i);
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {28'b0, req_ready, rsp_valid, rsp_err, dm_dmwr}, 32'h0);
    check("reset_data", rsp_rdata | dm_din | {22'b0, dm_addr}, 32'h0);
    rst_n = 1'b1;
    check("reset_rdy0", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check("reset_rdy1", {31'b0, req_ready}, 32'd1);

    // Directed scenarios on word 3 = 0x8899AABB
    do_req(1'b0, SZ_BYTE, 1'b1, 12'h00D, 32'h0, rd, lat, eg);
`ifdef LSU_SUBWORD_EN
    check("ldb_signed", rd, 32'hFFFFFFAA);
    check("ldb_lat", 32'(lat), 32'd3);
`else
    check("ldb_err_nosub", {31'b0, eg}, 32'd1);
`endif
    do_req(1'b0, SZ_BYTE, 1'b0, 12'h00D, 32'h0, rd, lat, eg);
`ifdef LSU_SUBWORD_EN
    check("ldb_unsigned", rd, 32'h000000AA);
`endif
    do_req(1'b1, SZ_HALF, 1'b0, 12'h00E, 32'h00001234, rd, lat, eg);
    do_req(1'b0, SZ_WORD, 1'b0, 12'h00C, 32'h0, rd, lat, eg);
`ifdef LSU_SUBWORD_EN
    check("sth_merge", rd, 32'h1234AABB);
`else
    check("sth_nowrite", rd, 32'h8899AABB);
    do_req(1'b0, SZ_BYTE, 1'b0, 12'h00C, 32'h0, rd, lat, eg);
    check("ldb00c_err", {31'b0, eg}, 32'd1);
    check("ldb00c_lat", 32'(lat), 32'd1);
`endif
    do_req(1'b1, SZ_WORD, 1'b0, 12'h010, 32'hDEADBEEF, rd, lat, eg);
    check("stw_lat", 32'(lat), 32'd2);
    do_req(1'b0, SZ_WORD, 1'b0, 12'h010, 32'h0, rd, lat, eg);
    check("ldw_data", rd, 32'hDEADBEEF);
    check("ldw_lat", 32'(lat), 32'd3);
    do_req(1'b0, SZ_WORD, 1'b0, 12'h006, 32'h0, rd, lat, eg);
    check("misalign_err", {31'b0, eg}, 32'd1);
    do_req(1'b0, SZ_WORD, 1'b0, 12'h080, 32'h0, rd, lat, eg);
    check("oor_err", {31'b0, eg}, 32'd1);
    check("oor_lat", 32'(lat), 32'd1);

    // Reset mid-operation
    reset_mid(1'b0, SZ_WORD, 12'h014, 32'h0, 2, 1'b0);
    reset_mid(1'b1, SZ_WORD, 12'h018, 32'hCAFEF00D, 1, 1'b1);
`ifdef LSU_SUBWORD_EN
    reset_mid(1'b1, SZ_BYTE, 12'h01D, 32'h00000055, 2, 1'b0);
`endif

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      logic [1:0]  sz;
      logic [9:0]  widx;
      logic [1:0]  lo;
      int          r;
      r = $urandom_range(0, 9);
      sz = (r < 3) ? SZ_BYTE : (r < 6) ? SZ_HALF : (r < 9) ? SZ_WORD : 2'b11;
      widx = 10'($urandom_range(0, DM_WORDS + 3));
      lo = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == SZ_WORD) lo = 2'b00;
        else if (sz == SZ_HALF) lo[0] = 1'b0;
      end
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             {widx, lo}, $urandom, rd, lat, eg);
    end

    for (int i = 0; i < DM_WORDS; i++) check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
